wb_exc_commit: RTL and testbench

- Writeback-stage register plus exception/ERTN commit controller.
- Sits directly upstream of the CSR file and drives its wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush and csr_we* inputs.
- Prioritises pending interrupt and stage exception flags, suppresses architectural writes of faulting instructions, and runs a redirect/flush handshake toward fetch.

---
 rtl/wb_exc_commit.sv | 213 +++++++++++++++++++++
 tb/tb_wb_exc_commit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_exc_commit.sv
// Writeback stage register with exception/ERTN commit, CSR/GPR write gating and fetch redirect handshake.
// Optional build macro WB_EX_STAT_EN: enables the saturating committed-exception counter on ex_count.
module wb_exc_commit #(
    parameter int unsigned FLUSH_MIN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_to_ws_valid,
    output logic        ws_allow_in,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_vaddr,
    input  logic [4:0]  ms_ex_flags,
    input  logic        ms_is_ertn,
    input  logic        ms_csr_we,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_csr_wmask,
    input  logic [31:0] ms_csr_wvalue,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_rf_waddr,
    input  logic [31:0] ms_rf_wdata,
    input  logic        has_int,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        ertn_flush,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic [31:0] ex_count
);

    localparam int unsigned CNT_W = 4;
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic {S_RUN, S_REDIR} state_t;

    // ex_flags bit order: {ale, brk, sys, ine, adef}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic [4:0]  ex_flags;
        logic        is_ertn;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } ws_t;

    state_t           state_q, state_d;
    logic             ws_valid_q, ws_valid_d;
    ws_t              ws_q, ws_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             redir_valid_q, redir_valid_d;
    logic [31:0]      redir_pc_q, redir_pc_d;
    logic             flush_q, flush_d;

    logic             commit, ex_hit, ertn_hit, normal, load;
    logic [5:0]       ecode;
    logic [31:0]      ex_vaddr;

    // Commit decode and exception priority
    always_comb begin
        commit   = ws_valid_q && (state_q == S_RUN);
        ex_hit   = commit && (has_int || (ws_q.ex_flags != 5'd0));
        ertn_hit = commit && !ex_hit && ws_q.is_ertn;
        normal   = commit && !ex_hit && !ertn_hit;
        ecode    = ECODE_INT;
        ex_vaddr = 32'd0;
        if (has_int) begin
            ecode = ECODE_INT;
        end else if (ws_q.ex_flags[0]) begin
            ecode    = ECODE_ADEF;
            ex_vaddr = ws_q.pc;
        end else if (ws_q.ex_flags[2]) begin
            ecode = ECODE_SYS;
        end else if (ws_q.ex_flags[3]) begin
            ecode = ECODE_BRK;
        end else if (ws_q.ex_flags[1]) begin
            ecode = ECODE_INE;
        end else if (ws_q.ex_flags[4]) begin
            ecode    = ECODE_ALE;
            ex_vaddr = ws_q.vaddr;
        end
    end

    assign ws_allow_in = (state_q == S_RUN) && (!ws_valid_q || commit);
    assign load        = ms_to_ws_valid && ws_allow_in;

    assign wb_ex       = ex_hit;
    assign wb_ecode    = ex_hit ? ecode : 6'd0;
    assign wb_esubcode = 9'd0;
    assign wb_pc       = ws_q.pc;
    assign wb_vaddr    = ex_hit ? ex_vaddr : 32'd0;
    assign ertn_flush  = ertn_hit;
    assign csr_we      = normal && ws_q.csr_we;
    assign csr_num     = ws_q.csr_num;
    assign csr_wmask   = ws_q.csr_wmask;
    assign csr_wvalue  = ws_q.csr_wvalue;
    assign rf_we       = normal && ws_q.rf_we;
    assign rf_waddr    = ws_q.rf_waddr;
    assign rf_wdata    = ws_q.rf_wdata;

    assign pipe_flush     = flush_q;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;

    // Stage register; a younger instruction accepted alongside a redirecting commit is wrong-path and dropped
    always_comb begin
        ws_d       = ws_q;
        ws_valid_d = ws_valid_q;
        if (commit) begin
            ws_valid_d = 1'b0;
        end
        if (load) begin
            ws_d.pc         = ms_pc;
            ws_d.vaddr      = ms_vaddr;
            ws_d.ex_flags   = ms_ex_flags;
            ws_d.is_ertn    = ms_is_ertn;
            ws_d.csr_we     = ms_csr_we;
            ws_d.csr_num    = ms_csr_num;
            ws_d.csr_wmask  = ms_csr_wmask;
            ws_d.csr_wvalue = ms_csr_wvalue;
            ws_d.rf_we      = ms_rf_we;
            ws_d.rf_waddr   = ms_rf_waddr;
            ws_d.rf_wdata   = ms_rf_wdata;
            ws_valid_d      = !(ex_hit || ertn_hit);
        end
    end

    // Redirect FSM: hold redirect until accepted and the minimum flush window has elapsed
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        case (state_q)
            S_RUN: begin
                if (ex_hit || ertn_hit) begin
                    redir_pc_d    = ex_hit ? csr_eentry : csr_era;
                    redir_valid_d = 1'b1;
                    cnt_d         = CNT_W'(FLUSH_MIN_CYCLES);
                    state_d       = S_REDIR;
                end
            end
            S_REDIR: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                if (redir_valid_q && redirect_ready && (cnt_q == '0)) begin
                    redir_valid_d = 1'b0;
                    state_d       = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
        flush_d = (state_d == S_REDIR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            ws_valid_q    <= 1'b0;
            ws_q          <= '0;
            cnt_q         <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ws_valid_q    <= ws_valid_d;
            ws_q          <= ws_d;
            cnt_q         <= cnt_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
        end
    end

`ifdef WB_EX_STAT_EN
    logic [31:0] ex_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_count_q <= 32'd0;
        end else if (ex_hit && (ex_count_q != 32'hFFFF_FFFF)) begin
            ex_count_q <= ex_count_q + 32'd1;
        end
    end

    assign ex_count = ex_count_q;
`else
    assign ex_count = 32'd0;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
// Self-checking bench for wb_exc_commit: directed scenarios plus random traffic against a transaction-level model.
module tb_wb_exc_commit;

    localparam int unsigned FLUSH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid, ws_allow_in;
    logic [31:0] ms_pc, ms_vaddr, ms_csr_wmask, ms_csr_wvalue, ms_rf_wdata;
    logic [4:0]  ms_ex_flags, ms_rf_waddr, rf_waddr;
    logic        ms_is_ertn, ms_csr_we, ms_rf_we, has_int;
    logic [13:0] ms_csr_num, csr_num;
    logic [31:0] csr_eentry, csr_era, wb_pc, wb_vaddr, csr_wmask, csr_wvalue, rf_wdata;
    logic        wb_ex, ertn_flush, csr_we, rf_we, pipe_flush, redirect_valid, redirect_ready;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] redirect_pc, ex_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_exc_commit #(.FLUSH_MIN_CYCLES(FLUSH)) dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
        .ms_pc(ms_pc), .ms_vaddr(ms_vaddr), .ms_ex_flags(ms_ex_flags), .ms_is_ertn(ms_is_ertn),
        .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask),
        .ms_csr_wvalue(ms_csr_wvalue), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
        .ms_rf_wdata(ms_rf_wdata), .has_int(has_int), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .ex_count(ex_count)
    );

    typedef struct {
        logic [31:0] pc, vaddr, cmask, cval, rdat;
        logic [4:0]  fl, rad;
        logic        ertn, cwe, rwe;
        logic [13:0] cnum;
    } ins_t;

    // Model: held instruction, whether a redirect is outstanding, and how long it has been outstanding
    bit          m_valid, n_valid, m_redir, n_redir;
    int          m_spent, n_spent;
    ins_t        m_ins, n_ins;
    logic [31:0] m_rpc, n_rpc, m_count, n_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_redir = 0; m_spent = 0; m_rpc = 0; m_count = 0;
        m_ins = '{default: '0};
    endtask

    // At the negedge: compare all outputs with the model, then compute the model's next step
    task automatic half_a();
        bit commit, take_ex, take_ertn, normal;
        logic [5:0]  ec;
        logic [31:0] va, exp_cnt;
        @(negedge clk);
        commit    = m_valid && !m_redir;
        take_ex   = commit && (has_int || m_ins.fl != 5'd0);
        take_ertn = commit && !take_ex && m_ins.ertn;
        normal    = commit && !take_ex && !take_ertn;
        ec = 6'h0; va = 32'd0;
        if (has_int)         ec = 6'h0;
        else if (m_ins.fl[0]) begin ec = 6'h8; va = m_ins.pc; end
        else if (m_ins.fl[2]) ec = 6'hB;
        else if (m_ins.fl[3]) ec = 6'hC;
        else if (m_ins.fl[1]) ec = 6'hD;
        else if (m_ins.fl[4]) begin ec = 6'h9; va = m_ins.vaddr; end
        check("allow_in", ws_allow_in, !m_redir);
        check("wb_ex", wb_ex, take_ex);
        check("ertn_flush", ertn_flush, take_ertn);
        if (take_ex) begin
            check("ecode", wb_ecode, ec);
            check("esubcode", wb_esubcode, 0);
            check("wb_vaddr", wb_vaddr, va);
        end
        if (commit) check("wb_pc", wb_pc, m_ins.pc);
        check("rf_we", rf_we, normal && m_ins.rwe);
        check("csr_we", csr_we, normal && m_ins.cwe);
        if (normal && m_ins.rwe) begin
            check("rf_waddr", rf_waddr, m_ins.rad);
            check("rf_wdata", rf_wdata, m_ins.rdat);
        end
        if (normal && m_ins.cwe) begin
            check("csr_num", csr_num, m_ins.cnum);
            check("csr_wmask", csr_wmask, m_ins.cmask);
            check("csr_wvalue", csr_wvalue, m_ins.cval);
        end
        check("pipe_flush", pipe_flush, m_redir);
        check("redirect_valid", redirect_valid, m_redir);
        if (m_redir) check("redirect_pc", redirect_pc, m_rpc);
`ifdef WB_EX_STAT_EN
        exp_cnt = m_count;
`else
        exp_cnt = 32'd0;
`endif
        check("ex_count", ex_count, exp_cnt);

        n_valid = m_valid; n_redir = m_redir; n_spent = m_spent; n_ins = m_ins; n_rpc = m_rpc;
        n_count = (take_ex && m_count != 32'hFFFF_FFFF) ? m_count + 1 : m_count;
        if (m_redir) begin
            if (redirect_ready && m_spent >= int'(FLUSH)) n_redir = 0;
            else n_spent = m_spent + 1;
        end else if (take_ex || take_ertn) begin
            n_redir = 1; n_spent = 0; n_valid = 0;
            n_rpc = take_ex ? csr_eentry : csr_era;
        end else begin
            n_valid = ms_to_ws_valid;
            n_ins = '{pc: ms_pc, vaddr: ms_vaddr, cmask: ms_csr_wmask, cval: ms_csr_wvalue,
                      rdat: ms_rf_wdata, fl: ms_ex_flags, rad: ms_rf_waddr, ertn: ms_is_ertn,
                      cwe: ms_csr_we, rwe: ms_rf_we, cnum: ms_csr_num};
        end
    endtask

    task automatic half_b();
        @(posedge clk);
        #1;
        m_valid = n_valid; m_redir = n_redir; m_spent = n_spent; m_ins = n_ins;
        m_rpc = n_rpc; m_count = n_count;
    endtask

    task automatic cycle();
        half_a();
        half_b();
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] fl, input logic ertn,
                         input logic cwe, input logic [31:0] va);
        ms_to_ws_valid = 1; ms_pc = pc; ms_ex_flags = fl; ms_is_ertn = ertn; ms_csr_we = cwe;
        ms_vaddr = va; ms_rf_we = 1; ms_rf_waddr = 5'($urandom); ms_rf_wdata = $urandom;
        ms_csr_num = 14'($urandom); ms_csr_wmask = $urandom; ms_csr_wvalue = $urandom;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 40 && m_redir; i++) cycle();
        check("redirect_exit", redirect_valid, 0);
    endtask

    initial begin
        int pf;
        reset = 1; ms_to_ws_valid = 0; has_int = 0; redirect_ready = 0;
        offer(0, 0, 0, 0, 0); ms_to_ws_valid = 0;
        csr_eentry = 32'h1C008000; csr_era = 32'h1C000404;
        model_reset();
        @(negedge clk);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_pipe_flush", pipe_flush, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_ex_count", ex_count, 0);
        check("rst_wb_ex", wb_ex, 0);
        check("rst_allow_in", ws_allow_in, 1);
        @(posedge clk); #1; reset = 0;

        // Plain GPR write
        offer(32'h1C000100, 0, 0, 0, 0); cycle(); ms_to_ws_valid = 0;
        half_a(); check("t1_rf_we", rf_we, 1); check("t1_allow", ws_allow_in, 1); half_b();

        // ALE with redirect held until ready
        offer(32'h1C000200, 5'b10000, 0, 0, 32'h3); cycle(); ms_to_ws_valid = 0;
        half_a(); check("t2_ecode", wb_ecode, 6'h9); check("t2_vaddr", wb_vaddr, 32'h3); half_b();
        for (int i = 0; i < 6; i++) cycle();
        half_a(); check("t2_held_pc", redirect_pc, 32'h1C008000); check("t2_held_v", redirect_valid, 1); half_b();
        redirect_ready = 1; wait_run();

        // Interrupt beats BRK and suppresses CSR write
        offer(32'h1C000300, 5'b01000, 0, 1, 0); has_int = 1; cycle(); ms_to_ws_valid = 0;
        half_a(); check("t3_ecode", wb_ecode, 6'h0); check("t3_csr_we", csr_we, 0); half_b();
        has_int = 0; wait_run();

        // ERTN, then ERTN+ADEF
        offer(32'h1C000400, 0, 1, 0, 0); cycle(); ms_to_ws_valid = 0;
        half_a(); check("t4_ertn", ertn_flush, 1); half_b();
        half_a(); check("t4_rpc", redirect_pc, 32'h1C000404); half_b();
        wait_run();
        offer(32'h1C000400, 5'b00001, 1, 0, 0); cycle(); ms_to_ws_valid = 0;
        half_a(); check("t4_adef_ertn", ertn_flush, 0); check("t4_adef_va", wb_vaddr, 32'h1C000400); half_b();
        wait_run();

        // Minimum flush window with ready tied high; offers during redirect are dropped
        offer(32'h1C000500, 5'b01000, 0, 0, 0); cycle();
        offer(32'h1C000504, 0, 0, 0, 0);
        pf = 0;
        for (int i = 0; i < 10; i++) begin
            half_a(); if (pipe_flush) pf++; half_b();
            ms_to_ws_valid = m_redir;
        end
        check("t5_flush_cycles", pf, FLUSH + 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            offer($urandom, ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
                  ($urandom_range(0, 7) == 0), 1'($urandom), $urandom);
            ms_to_ws_valid = ($urandom_range(0, 9) < 7);
            ms_rf_we = 1'($urandom);
            has_int = ($urandom_range(0, 9) == 0);
            redirect_ready = ($urandom_range(0, 1) == 0);
            csr_eentry = $urandom; csr_era = $urandom;
            cycle();
        end

        // Reset while redirecting
        has_int = 0; redirect_ready = 0; wait_run_prep: begin end
        offer(32'h1C000600, 5'b00100, 0, 0, 0); cycle(); ms_to_ws_valid = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("t6_in_redir", redirect_valid, 1);
        @(negedge clk); #2; reset = 1; #1;
        check("t6_rst_rv", redirect_valid, 0);
        check("t6_rst_pf", pipe_flush, 0);
        model_reset();
        @(posedge clk); #1; reset = 0;
        half_a(); check("t6_allow", ws_allow_in, 1); half_b();

        // Three exceptions after reset
        redirect_ready = 1;
        for (int k = 0; k < 3; k++) begin
            offer(32'h1C000700 + 32'(k * 4), 5'b00100, 0, 0, 0); cycle(); ms_to_ws_valid = 0;
            cycle(); wait_run();
        end
`ifdef WB_EX_STAT_EN
        check("t6_ex_count", ex_count, 3);
`else
        check("t6_ex_count", ex_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
